// File: rtl/eco_msg_parser_pkg.sv
// Shared constants and types for the CSL/SAM frame parser.
package eco_msg_pkg;

  localparam int unsigned NODE_W = 5;

  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_A    = 8'h41;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR2, ST_HDR3, ST_SEP, ST_DIG_HI, ST_DIG_LO, ST_TERM
  } state_e;

  typedef enum logic {
    FT_CSL, FT_SAM
  } frame_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/eco_msg_parser_if.sv
// Byte input and decoded-frame outputs of the parser.
interface eco_msg_parser_if;
  logic [7:0]                     rx_data;
  logic                           rx_valid;
  logic                           csl_valid;
  logic [eco_msg_pkg::NODE_W-1:0] csl_start;
  logic [eco_msg_pkg::NODE_W-1:0] csl_end;
  logic [eco_msg_pkg::NODE_W-1:0] csl_prev_node_of_end_point;
  logic                           sam_valid;
  logic [eco_msg_pkg::NODE_W-1:0] sam_pick;
  logic [eco_msg_pkg::NODE_W-1:0] sam_place;
  logic [1:0]                     subunit;
  logic                           frame_err;

  // UART side: drives bytes, observes decoded results
  modport master (
    output rx_data, rx_valid,
    input  csl_valid, csl_start, csl_end, csl_prev_node_of_end_point,
    input  sam_valid, sam_pick, sam_place, subunit, frame_err
  );

  // Parser side
  modport slave (
    input  rx_data, rx_valid,
    output csl_valid, csl_start, csl_end, csl_prev_node_of_end_point,
    output sam_valid, sam_pick, sam_place, subunit, frame_err
  );
endinterface

// File: rtl/eco_msg_parser_ascii2_to_node.sv
// Two ASCII decimal digits -> 7-bit value, with digit and range flags.
module ascii2_to_node
  import eco_msg_pkg::*;
#(
  parameter int unsigned MAX_NODE = 31
) (
  input  logic [7:0] hi_ch,
  input  logic [7:0] lo_ch,
  output logic [6:0] value,
  output logic       not_digit,
  output logic       out_of_range
);

  // ASCII digits sit at 0x30..0x39, so the low nibble is the digit value
  always_comb begin
    not_digit    = !is_digit(hi_ch) || !is_digit(lo_ch);
    value        = 7'(hi_ch[3:0]) * 7'd10 + 7'(lo_ch[3:0]);
    out_of_range = !not_digit && (value > 7'(MAX_NODE));
  end

endmodule

// File: rtl/eco_msg_parser.sv
// CSL/SAM fixed-format frame parser with shadowed, registered outputs.
module eco_msg_parser
  import eco_msg_pkg::*;
#(
  parameter int unsigned MAX_NODE  = 31,
  parameter logic [7:0]  TERM_CHAR = 8'h23
) (
  input logic             clk,
  input logic             rst_n,
  eco_msg_parser_if.slave bus
);

  state_e                  state_q, state_d;
  frame_e                  ftype_q, ftype_d;
  logic [1:0]              idx_q, idx_d;
  logic                    done_q, done_d;      // all fields in, awaiting '-' then terminator
  logic [7:0]              hi_q, hi_d;
  logic [2:0][NODE_W-1:0]  shadow_q, shadow_d;
  logic                    csl_valid_q, csl_valid_d;
  logic                    sam_valid_q, sam_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic [NODE_W-1:0]       csl_start_q, csl_start_d;
  logic [NODE_W-1:0]       csl_end_q, csl_end_d;
  logic [NODE_W-1:0]       csl_prev_q, csl_prev_d;
  logic [NODE_W-1:0]       sam_pick_q, sam_pick_d;
  logic [NODE_W-1:0]       sam_place_q, sam_place_d;
  logic [1:0]              subunit_q, subunit_d;

  logic [6:0] conv_val;
  logic       conv_bad_digit, conv_range;
  logic       err;
  logic [1:0] last_idx;

  ascii2_to_node #(.MAX_NODE(MAX_NODE)) u_conv (
    .hi_ch       (hi_q),
    .lo_ch       (bus.rx_data),
    .value       (conv_val),
    .not_digit   (conv_bad_digit),
    .out_of_range(conv_range)
  );

  assign last_idx = (ftype_q == FT_CSL) ? 2'd2 : 2'd1;

  // Next-state: header/field matching, error restart, and frame publish
  always_comb begin
    state_d     = state_q;
    ftype_d     = ftype_q;
    idx_d       = idx_q;
    done_d      = done_q;
    hi_d        = hi_q;
    shadow_d    = shadow_q;
    csl_start_d = csl_start_q;
    csl_end_d   = csl_end_q;
    csl_prev_d  = csl_prev_q;
    sam_pick_d  = sam_pick_q;
    sam_place_d = sam_place_q;
    subunit_d   = subunit_q;
    csl_valid_d = 1'b0;
    sam_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err         = 1'b0;

    if (bus.rx_valid) begin
      case (state_q)
        ST_HDR2: begin
          if (bus.rx_data == ((ftype_q == FT_CSL) ? CH_S : CH_A)) state_d = ST_HDR3;
          else err = 1'b1;
        end
        ST_HDR3: begin
          if (bus.rx_data == ((ftype_q == FT_CSL) ? CH_L : CH_M)) state_d = ST_SEP;
          else err = 1'b1;
        end
        ST_SEP: begin
          if (bus.rx_data == CH_DASH) state_d = done_q ? ST_TERM : ST_DIG_HI;
          else err = 1'b1;
        end
        ST_DIG_HI: begin
          if (is_digit(bus.rx_data)) begin
            hi_d    = bus.rx_data;
            state_d = ST_DIG_LO;
          end else begin
            err = 1'b1;
          end
        end
        ST_DIG_LO: begin
          if (conv_bad_digit || conv_range) begin
            err = 1'b1;
          end else begin
            shadow_d[idx_q] = conv_val[NODE_W-1:0];
            if (idx_q == last_idx) done_d = 1'b1;
            else                   idx_d  = idx_q + 2'd1;
            state_d = ST_SEP;
          end
        end
        ST_TERM: begin
          if (bus.rx_data == TERM_CHAR) begin
            if (ftype_q == FT_CSL) begin
              csl_start_d = shadow_q[0];
              csl_end_d   = shadow_q[1];
              csl_prev_d  = shadow_q[2];
              csl_valid_d = 1'b1;
              subunit_d   = 2'd0;
            end else begin
              sam_pick_d  = shadow_q[0];
              sam_place_d = shadow_q[1];
              sam_valid_d = 1'b1;
              subunit_d   = (subunit_q == 2'd3) ? 2'd3 : subunit_q + 2'd1;
            end
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            done_d  = 1'b0;
          end else begin
            err = 1'b1;
          end
        end
        default: ;
      endcase

      // Idle bytes and the byte that broke a frame both get a chance to start one
      if (state_q == ST_IDLE || err) begin
        if (err) begin
          frame_err_d = 1'b1;
          shadow_d    = '0;
          idx_d       = 2'd0;
          done_d      = 1'b0;
        end
        state_d = ST_IDLE;
        if (bus.rx_data == CH_C) begin
          state_d = ST_HDR2;
          ftype_d = FT_CSL;
        end else if (bus.rx_data == CH_S) begin
          state_d = ST_HDR2;
          ftype_d = FT_SAM;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ftype_q     <= FT_CSL;
      idx_q       <= 2'd0;
      done_q      <= 1'b0;
      hi_q        <= 8'd0;
      shadow_q    <= '0;
      csl_valid_q <= 1'b0;
      sam_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      csl_start_q <= '0;
      csl_end_q   <= '0;
      csl_prev_q  <= '0;
      sam_pick_q  <= '0;
      sam_place_q <= '0;
      subunit_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ftype_q     <= ftype_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      hi_q        <= hi_d;
      shadow_q    <= shadow_d;
      csl_valid_q <= csl_valid_d;
      sam_valid_q <= sam_valid_d;
      frame_err_q <= frame_err_d;
      csl_start_q <= csl_start_d;
      csl_end_q   <= csl_end_d;
      csl_prev_q  <= csl_prev_d;
      sam_pick_q  <= sam_pick_d;
      sam_place_q <= sam_place_d;
      subunit_q   <= subunit_d;
    end
  end

  assign bus.csl_valid                  = csl_valid_q;
  assign bus.csl_start                  = csl_start_q;
  assign bus.csl_end                    = csl_end_q;
  assign bus.csl_prev_node_of_end_point = csl_prev_q;
  assign bus.sam_valid                  = sam_valid_q;
  assign bus.sam_pick                   = sam_pick_q;
  assign bus.sam_place                  = sam_place_q;
  assign bus.subunit                    = subunit_q;
  assign bus.frame_err                  = frame_err_q;

endmodule

// File: tb/tb_eco_msg_parser.sv
// Scoreboard bench for eco_msg_parser: template-matching reference model,
// directed frames plus randomized frames, noise, corruption and resets.
module tb_eco_msg_parser;

  localparam int         MAXN = 31;
  localparam logic [7:0] TERM = 8'h23;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eco_msg_parser_if bus();

  eco_msg_parser #(.MAX_NODE(MAXN), .TERM_CHAR(TERM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int kind;   // 0 csl, 1 sam, 2 error
    int cyc;
    int cs, ce, cp, sp, sl, sub;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int m_cs, m_ce, m_cp, m_sp, m_sl, m_sub;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void push_exp(input int kind, input int ecyc);
    exp_t e;
    e.kind = kind; e.cyc = ecyc;
    e.cs = m_cs; e.ce = m_ce; e.cp = m_cp;
    e.sp = m_sp; e.sl = m_sl; e.sub = m_sub;
    exp_q.push_back(e);
  endfunction

  function automatic int fld(input int p);
    return (int'(cur[p]) - 48) * 10 + int'(cur[p+1]) - 48;
  endfunction

  function automatic void model_reset();
    cur.delete();
    m_cs = 0; m_ce = 0; m_cp = 0; m_sp = 0; m_sl = 0; m_sub = 0;
  endfunction

  // Reference: match the collected bytes against a literal frame template
  function automatic void model_byte(input logic [7:0] b, input int ecyc);
    string tmpl;
    logic [7:0] t, p;
    int pos;
    bit ok;
    if (cur.size() == 0) begin
      if (b == "C" || b == "S") cur.push_back(b);
      return;
    end
    tmpl = (cur[0] == "C") ? "CSL-dd-dd-dd-#" : "SAM-dd-dd-#";
    pos  = cur.size();
    t    = tmpl[pos];
    p    = tmpl[pos-1];
    if (t == "d") begin
      ok = (b >= "0") && (b <= "9");
      if (ok && p == "d") ok = ((int'(cur[pos-1]) - 48) * 10 + int'(b) - 48) <= MAXN;
    end else if (t == "#") begin
      ok = (b == TERM);
    end else begin
      ok = (b == t);
    end
    if (!ok) begin
      push_exp(2, ecyc);
      cur.delete();
      if (b == "C" || b == "S") cur.push_back(b);
    end else begin
      cur.push_back(b);
      if (cur.size() == tmpl.len()) begin
        if (cur[0] == "C") begin
          m_cs = fld(4); m_ce = fld(7); m_cp = fld(10); m_sub = 0;
          push_exp(0, ecyc);
        end else begin
          m_sp = fld(4); m_sl = fld(7); m_sub = (m_sub < 3) ? m_sub + 1 : 3;
          push_exp(1, ecyc);
        end
        cur.delete();
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    model_byte(b, cyc + 1);
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      if (maxgap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, maxgap));
      send_byte(s[i]);
    end
  endtask

  task automatic do_reset();
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_csl_start", int'(bus.csl_start), 0);
    chk("async_rst_csl_end", int'(bus.csl_end), 0);
    chk("async_rst_sam_pick", int'(bus.sam_pick), 0);
    chk("async_rst_subunit", int'(bus.subunit), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_frame();
    string s, cs;
    bit    is_csl;
    int    v, pos;
    cs = "CSAML-#0123456789XZ";
    if ($urandom_range(0, 9) < 2) begin
      repeat ($urandom_range(1, 3)) send_byte(cs[$urandom_range(0, cs.len() - 1)]);
    end
    is_csl = 1'($urandom_range(0, 1));
    s = is_csl ? "CSL" : "SAM";
    for (int f = 0; f < (is_csl ? 3 : 2); f++) begin
      v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(0, MAXN);
      s = {s, $sformatf("-%02d", v)};
    end
    s = {s, "-#"};
    if ($urandom_range(0, 4) == 0) begin
      pos = $urandom_range(1, s.len() - 1);
      s[pos] = cs[$urandom_range(0, cs.len() - 1)];
    end
    send_str(s, ($urandom_range(0, 1) == 0) ? 0 : 3);
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    exp_t e;
    int   np;
    if (rst_n && (bus.csl_valid || bus.sam_valid || bus.frame_err)) begin
      np = int'(bus.csl_valid) + int'(bus.sam_valid) + int'(bus.frame_err);
      chk("one_pulse", np, 1);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: csl=%0b sam=%0b err=%0b, expected none (cycle %0d)",
                 bus.csl_valid, bus.sam_valid, bus.frame_err, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("kind", bus.frame_err ? 2 : (bus.sam_valid ? 1 : 0), e.kind);
        chk("latency_cycle", cyc, e.cyc);
        chk("csl_start", int'(bus.csl_start), e.cs);
        chk("csl_end", int'(bus.csl_end), e.ce);
        chk("csl_prev", int'(bus.csl_prev_node_of_end_point), e.cp);
        chk("sam_pick", int'(bus.sam_pick), e.sp);
        chk("sam_place", int'(bus.sam_place), e.sl);
        chk("subunit", int'(bus.subunit), e.sub);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_csl_valid", int'(bus.csl_valid), 0);
    chk("rst_sam_valid", int'(bus.sam_valid), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_csl_start", int'(bus.csl_start), 0);
    chk("rst_csl_prev", int'(bus.csl_prev_node_of_end_point), 0);
    chk("rst_sam_place", int'(bus.sam_place), 0);
    chk("rst_subunit", int'(bus.subunit), 0);
    rst_n = 1'b1;

    send_str("CSL-05-12-11-#", 0);
    idle(2);
    chk("t1_csl_start", int'(bus.csl_start), 5);
    chk("t1_csl_end", int'(bus.csl_end), 12);
    chk("t1_csl_prev", int'(bus.csl_prev_node_of_end_point), 11);
    chk("t1_subunit", int'(bus.subunit), 0);

    repeat (4) send_str("SAM-03-07-#", 0);
    idle(2);
    chk("t2_subunit_sat", int'(bus.subunit), 3);
    send_str("CSL-01-01-01-#", 0);
    idle(2);
    chk("t2_subunit_clr", int'(bus.subunit), 0);

    send_str("SAM-3A-07-#", 0);
    send_str("CSL-40-01-02-#", 0);
    send_str("SCSL-01-02-03-#", 0);
    idle(2);
    chk("t5_csl_end", int'(bus.csl_end), 2);
    chk("t3_sam_pick_held", int'(bus.sam_pick), 3);

    send_str("CSL-01-", 0);
    do_reset();
    send_str("SAM-09-10-#", 0);
    idle(2);
    chk("t6_csl_start", int'(bus.csl_start), 0);
    chk("t6_sam_place", int'(bus.sam_place), 10);
    chk("t6_subunit", int'(bus.subunit), 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      rand_frame();
    end

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_csl_start", int'(bus.csl_start), m_cs);
    chk("final_csl_prev", int'(bus.csl_prev_node_of_end_point), m_cp);
    chk("final_sam_pick", int'(bus.sam_pick), m_sp);
    chk("final_subunit", int'(bus.subunit), m_sub);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
